display_scheduler: RTL

Arbitrates the shared two-digit 7-segment display between the game's value sources: score, remaining game time, countdown, high score and miss/hit event feedback. The choice of source is driven by game state and by mole events. It sits between game_control_fsm/score_counter/sec_counter and two_digit_7seg, replacing the direct display_value path. It also owns the high-score register.

---
 rtl/disp_pkg.sv | 45 ++++
 rtl/display_scheduler_tick_timer.sv | 34 +++
 rtl/display_scheduler.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/disp_pkg.sv
// Shared encodings for the display scheduler: value sources, game states
// (common with game_control_fsm) and the scheduler state enum.
package disp_pkg;

  localparam logic [2:0] SRC_SCORE     = 3'd0;
  localparam logic [2:0] SRC_TIME      = 3'd1;
  localparam logic [2:0] SRC_COUNTDOWN = 3'd2;
  localparam logic [2:0] SRC_HISCORE   = 3'd3;
  localparam logic [2:0] SRC_LAST      = 3'd4;

  localparam logic [1:0] GS_IDLE      = 2'd0;
  localparam logic [1:0] GS_COUNTDOWN = 2'd1;
  localparam logic [1:0] GS_PLAY      = 2'd2;
  localparam logic [1:0] GS_OVER      = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CD       = 3'd1,
    ST_PLAY_ROT = 3'd2,
    ST_HIT_HOLD = 3'd3,
    ST_MISS     = 3'd4,
    ST_OVER     = 3'd5
  } sched_state_e;

  function automatic sched_state_e gs_to_state(input logic [1:0] gs);
    sched_state_e st;
    case (gs)
      GS_IDLE:      st = ST_IDLE;
      GS_COUNTDOWN: st = ST_CD;
      GS_PLAY:      st = ST_PLAY_ROT;
      GS_OVER:      st = ST_OVER;
      default:      st = ST_IDLE;
    endcase
    return st;
  endfunction

  // Seconds left in the game, clamped at zero once elapsed time reaches the length.
  function automatic logic [7:0] remaining_time(input logic [5:0] elapsed, input logic [7:0] len);
    logic [7:0] rem;
    if ({2'b00, elapsed} >= len) rem = 8'd0;
    else                         rem = len - {2'b00, elapsed};
    return rem;
  endfunction

endpackage

// File: rtl/display_scheduler_tick_timer.sv
// tick_timer: elapsed-tick counter that wraps at TICKS-1 and flags the wrap
// cycle on done; clr restarts it from zero.
module tick_timer #(
  parameter int TICKS = 1,
  parameter int CNT_W = 28
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic done
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICKS - 1);

  logic [CNT_W-1:0] cnt_r;

  assign done = en && (cnt_r == LAST);

  // Count while enabled, wrapping at LAST; clear has priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (en) begin
      if (cnt_r == LAST) cnt_r <= '0;
      else               cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/display_scheduler.sv
// display_scheduler: picks which game value drives the two-digit display and
// owns the high-score register (present only when HISCORE_EN is defined).
module display_scheduler
  import disp_pkg::*;
#(
  parameter int ROTATE_TICKS = 200_000_000,
  parameter int HOLD_TICKS   = 50_000_000,
  parameter int BLINK_TICKS  = 25_000_000,
  parameter int GAME_LEN     = 30,
  parameter int CNT_W        = 28
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] game_state,
  input  logic [5:0] countdown_sec,
  input  logic [5:0] game_time_sec,
  input  logic [7:0] score,
  input  logic       hit_pulse,
  input  logic       timeout_pulse,
  input  logic       clear_hiscore,
  output logic [7:0] display_value,
  output logic [2:0] display_src,
  output logic       blank
);

  localparam logic [7:0] GAME_LEN_V = 8'(GAME_LEN);

  sched_state_e state_r, state_s;
  logic       rot_r, rot_s;
  logic       ph_r, ph_s;
  logic [1:0] prev_gs_r;
  logic       slot_clr_s, slot_en_s, slot_done_s;
  logic       hold_clr_s, hold_en_s, hold_done_s;
  logic       blink_clr_s, blink_en_s, blink_done_s;
  logic [7:0] val_s;
  logic [2:0] src_s;
  logic       blank_s;

  tick_timer #(.TICKS(ROTATE_TICKS), .CNT_W(CNT_W)) u_slot (
    .clk(clk), .rst_n(rst_n), .clr(slot_clr_s), .en(slot_en_s), .done(slot_done_s));
  tick_timer #(.TICKS(HOLD_TICKS), .CNT_W(CNT_W)) u_hold (
    .clk(clk), .rst_n(rst_n), .clr(hold_clr_s), .en(hold_en_s), .done(hold_done_s));
  tick_timer #(.TICKS(BLINK_TICKS), .CNT_W(CNT_W)) u_blink (
    .clk(clk), .rst_n(rst_n), .clr(blink_clr_s), .en(blink_en_s), .done(blink_done_s));

`ifdef HISCORE_EN
  logic [7:0] hiscore_r;

  // Clear beats the end-of-game update; only a PLAY->OVER transition may raise it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hiscore_r <= 8'd0;
    end else if (clear_hiscore) begin
      hiscore_r <= 8'd0;
    end else if ((prev_gs_r == GS_PLAY) && (game_state == GS_OVER) && (score > hiscore_r)) begin
      hiscore_r <= score;
    end else begin
      hiscore_r <= hiscore_r;
    end
  end
`else
  logic unused_s;
  assign unused_s = clear_hiscore;
`endif

  // State, rotation/blink phase and last-seen game state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      rot_r     <= 1'b0;
      ph_r      <= 1'b0;
      prev_gs_r <= GS_IDLE;
    end else begin
      state_r   <= state_s;
      rot_r     <= rot_s;
      ph_r      <= ph_s;
      prev_gs_r <= game_state;
    end
  end

  // Next state: a game_state change overrides everything, otherwise per-state events.
  always_comb begin
    state_s     = state_r;
    rot_s       = rot_r;
    ph_s        = ph_r;
    slot_clr_s  = 1'b0;
    slot_en_s   = 1'b0;
    hold_clr_s  = 1'b0;
    hold_en_s   = 1'b0;
    blink_clr_s = 1'b0;
    blink_en_s  = 1'b0;
    if (game_state != prev_gs_r) begin
      state_s     = gs_to_state(game_state);
      rot_s       = 1'b0;
      ph_s        = 1'b0;
      slot_clr_s  = 1'b1;
      hold_clr_s  = 1'b1;
      blink_clr_s = 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
`ifdef HISCORE_EN
          slot_en_s = 1'b1;
          if (slot_done_s) rot_s = ~rot_r;
          else             rot_s = rot_r;
`else
          slot_clr_s = 1'b1;
`endif
        end
        ST_CD: state_s = ST_CD;
        ST_PLAY_ROT: begin
          if (hit_pulse) begin
            state_s    = ST_HIT_HOLD;
            hold_clr_s = 1'b1;
          end else if (timeout_pulse) begin
            state_s     = ST_MISS;
            rot_s       = 1'b0;
            blink_clr_s = 1'b1;
          end else begin
            slot_en_s = 1'b1;
            if (slot_done_s) rot_s = ~rot_r;
            else             rot_s = rot_r;
          end
        end
        ST_HIT_HOLD: begin
          if (hit_pulse) begin
            hold_clr_s = 1'b1;
          end else begin
            hold_en_s = 1'b1;
            if (hold_done_s) begin
              state_s    = ST_PLAY_ROT;
              rot_s      = 1'b1;
              slot_clr_s = 1'b1;
            end else begin
              state_s = ST_HIT_HOLD;
            end
          end
        end
        // rot doubles as the blink phase here: 0 = blanked half, 1 = lit half.
        ST_MISS: begin
          if (hit_pulse) begin
            state_s    = ST_HIT_HOLD;
            hold_clr_s = 1'b1;
          end else if (timeout_pulse) begin
            rot_s       = 1'b0;
            blink_clr_s = 1'b1;
          end else begin
            blink_en_s = 1'b1;
            if (blink_done_s) begin
              if (rot_r) begin
                state_s    = ST_PLAY_ROT;
                rot_s      = 1'b0;
                slot_clr_s = 1'b1;
              end else begin
                rot_s = 1'b1;
              end
            end else begin
              rot_s = rot_r;
            end
          end
        end
        ST_OVER: begin
          blink_en_s = 1'b1;
          if (blink_done_s) begin
            ph_s = ~ph_r;
            if (ph_r) rot_s = ~rot_r;
            else      rot_s = rot_r;
          end else begin
            ph_s = ph_r;
          end
        end
        default: begin
          state_s = ST_IDLE;
          rot_s   = 1'b0;
          ph_s    = 1'b0;
        end
      endcase
    end
  end

  // Output selection from the current state.
  always_comb begin
    val_s   = 8'd0;
    src_s   = SRC_LAST;
    blank_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
`ifdef HISCORE_EN
        if (rot_r) begin
          val_s = score;
          src_s = SRC_LAST;
        end else begin
          val_s = hiscore_r;
          src_s = SRC_HISCORE;
        end
`else
        val_s = score;
        src_s = SRC_LAST;
`endif
      end
      ST_CD: begin
        val_s = {2'b00, countdown_sec};
        src_s = SRC_COUNTDOWN;
      end
      ST_PLAY_ROT: begin
        if (rot_r) begin
          val_s = remaining_time(game_time_sec, GAME_LEN_V);
          src_s = SRC_TIME;
        end else begin
          val_s = score;
          src_s = SRC_SCORE;
        end
      end
      ST_HIT_HOLD: begin
        val_s = score;
        src_s = SRC_SCORE;
      end
      ST_MISS: begin
        val_s   = score;
        src_s   = SRC_SCORE;
        blank_s = ~rot_r;
      end
      ST_OVER: begin
        val_s   = score;
        src_s   = SRC_SCORE;
        blank_s = rot_r;
      end
      default: begin
        val_s   = 8'd0;
        src_s   = SRC_LAST;
        blank_s = 1'b0;
      end
    endcase
  end

  // Registered display outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      display_value <= 8'd0;
      display_src   <= SRC_LAST;
      blank         <= 1'b0;
    end else begin
      display_value <= val_s;
      display_src   <= src_s;
      blank         <= blank_s;
    end
  end

endmodule
